// File: rtl/tile_map_scroller_if.sv
// Column-fetch bus between the tile map scroller (master) and level memory (slave).
// The master holds col_req and col_addr until the slave returns col_valid with col_data.
`timescale 1ns/1ps
interface tile_map_scroller_if #(
  parameter int COL_ADDR_W = 8,
  parameter int NUM_ROWS   = 10,
  parameter int TILE_BITS  = 3
);
  logic                          col_req;
  logic [COL_ADDR_W-1:0]         col_addr;
  logic                          col_valid;
  logic [NUM_ROWS*TILE_BITS-1:0] col_data;

  modport master (
    output col_req,
    output col_addr,
    input  col_valid,
    input  col_data
  );

  modport slave (
    input  col_req,
    input  col_addr,
    output col_valid,
    output col_data
  );
endinterface

// File: rtl/tile_map_scroller.sv
// Scrolling tile map: NUM_COLS x NUM_ROWS tiles, filled and scrolled one column at
// a time from level memory, with single-tile writes, a registered draw lookup and
// combinational collision probes, all addressed in pixel coordinates.
// Build option SOLID_BORDER_EN: out-of-range probes read as all-ones (solid edge)
// instead of empty; tile_out and writes are not affected.
`timescale 1ns/1ps
module tile_map_scroller #(
  parameter int NUM_COLS   = 10,
  parameter int NUM_ROWS   = 10,
  parameter int TILE_BITS  = 3,
  parameter int TILE_PX    = 40,
  parameter int ORIGIN_X   = 120,
  parameter int ORIGIN_Y   = 40,
  parameter int NUM_PROBES = 6,
  parameter int COL_ADDR_W = 8
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           shift_req,
  output logic                           busy,
  output logic                           ready,
  tile_map_scroller_if.master            col,
  input  logic                           wr_en,
  input  logic [9:0]                     wr_x,
  input  logic [9:0]                     wr_y,
  input  logic [TILE_BITS-1:0]           wr_tile,
  input  logic [9:0]                     drawX,
  input  logic [9:0]                     drawY,
  output logic [TILE_BITS-1:0]           tile_out,
  input  logic [NUM_PROBES*10-1:0]       probe_x,
  input  logic [NUM_PROBES*10-1:0]       probe_y,
  output logic [NUM_PROBES*TILE_BITS-1:0] probe_tile,
  output logic [COL_ADDR_W-1:0]          current_col
);

  localparam int CX_W   = $clog2(NUM_COLS);
  localparam int RY_W   = $clog2(NUM_ROWS);
  localparam int COL_W  = NUM_ROWS * TILE_BITS;
  localparam int SPAN_X = NUM_COLS * TILE_PX;
  localparam int SPAN_Y = NUM_ROWS * TILE_PX;

`ifdef SOLID_BORDER_EN
  localparam logic [TILE_BITS-1:0] BORDER_TILE = '1;
`else
  localparam logic [TILE_BITS-1:0] BORDER_TILE = '0;
`endif

  typedef enum logic [1:0] {FILL, IDLE, FETCH} state_t;

  state_t                  state;
  state_t                  state_d;
  logic                    col_req_q;
  logic                    req_d;
  logic [CX_W-1:0]         fill_idx;
  logic [COL_W-1:0]        cols [NUM_COLS];
  logic [TILE_BITS-1:0]    tile_out_p1;

  logic                    fill_fire;
  logic                    shift_fire;
  logic signed [15:0]      wr_ox;
  logic signed [15:0]      wr_oy;
  logic                    wr_in_range;
  logic [CX_W-1:0]         wr_cx;
  logic [RY_W-1:0]         wr_ry;
  logic                    wr_fire;
  logic [CX_W-1:0]         wr_tgt;

  // Signed offset of a pixel from the grid origin; negative means left/above the grid.
  function automatic logic signed [15:0] px_offset(input logic [9:0] px, input int origin);
    return signed'({6'd0, px}) - signed'(16'(origin));
  endfunction

  // True when an offset lies inside [0, span); the sign test stops wrap aliasing.
  function automatic logic in_span(input logic signed [15:0] off, input int span);
    return !off[15] && (off < signed'(16'(span)));
  endfunction

  // Tile index of a non-negative offset.
  function automatic logic [15:0] tile_index(input logic signed [15:0] off);
    return 16'(off / signed'(16'(TILE_PX)));
  endfunction

  // Tile under a pixel, or oor when the pixel lies outside the grid.
  function automatic logic [TILE_BITS-1:0] lookup(input logic [9:0] x, input logic [9:0] y,
                                                  input logic [TILE_BITS-1:0] oor);
    logic signed [15:0] ox;
    logic signed [15:0] oy;
    logic [CX_W-1:0]    cx;
    logic [RY_W-1:0]    ry;
    ox = px_offset(x, ORIGIN_X);
    oy = px_offset(y, ORIGIN_Y);
    if (!(in_span(ox, SPAN_X) && in_span(oy, SPAN_Y))) return oor;
    cx = CX_W'(tile_index(ox));
    ry = RY_W'(tile_index(oy));
    return cols[cx][ry*TILE_BITS +: TILE_BITS];
  endfunction

  assign fill_fire  = (state == FILL)  && col_req_q && col.col_valid;
  assign shift_fire = (state == FETCH) && col_req_q && col.col_valid;

  assign col.col_req  = col_req_q;
  assign col.col_addr = current_col;
  assign tile_out     = tile_out_p1;

  // Decode the write target; a write on the shift edge follows its column one step left.
  always_comb begin
    wr_ox       = px_offset(wr_x, ORIGIN_X);
    wr_oy       = px_offset(wr_y, ORIGIN_Y);
    wr_in_range = in_span(wr_ox, SPAN_X) && in_span(wr_oy, SPAN_Y);
    wr_cx       = CX_W'(tile_index(wr_ox));
    wr_ry       = RY_W'(tile_index(wr_oy));
    wr_fire     = wr_en && wr_in_range && (state != FILL) && !(shift_fire && (wr_cx == '0));
    wr_tgt      = shift_fire ? (wr_cx - 1'b1) : wr_cx;
  end

  // State register and the registered column request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= FILL;
      col_req_q <= 1'b0;
    end else begin
      state     <= state_d;
      col_req_q <= req_d;
    end
  end

  // Next-state: fill until every column is loaded, then fetch one column per shift.
  always_comb begin
    state_d = state;
    case (state)
      FILL:    if (fill_fire && (fill_idx == CX_W'(NUM_COLS - 1))) state_d = IDLE;
      IDLE:    if (shift_req) state_d = FETCH;
      FETCH:   if (shift_fire) state_d = IDLE;
      default: state_d = FILL;
    endcase
  end

  // Outputs: request follows the coming state; busy/ready follow the current state.
  always_comb begin
    req_d = (state_d == FILL) || (state_d == FETCH);
    busy  = (state != IDLE);
    ready = (state != FILL);
  end

  // Tile storage, fill/column counters and the registered draw lookup.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_COLS; i++) cols[i] <= '0;
      fill_idx    <= '0;
      current_col <= '0;
      tile_out_p1 <= '0;
    end else begin
      if (fill_fire) begin
        cols[fill_idx] <= col.col_data;
        fill_idx       <= fill_idx + 1'b1;
      end
      if (shift_fire) begin
        for (int i = 0; i < NUM_COLS - 1; i++) cols[i] <= cols[i+1];
        cols[NUM_COLS-1] <= col.col_data;
      end
      if (fill_fire || shift_fire) current_col <= current_col + 1'b1;
      if (wr_fire) cols[wr_tgt][wr_ry*TILE_BITS +: TILE_BITS] <= wr_tile;
      tile_out_p1 <= lookup(drawX, drawY, '0);
    end
  end

  // Collision probes read the current tile array directly.
  always_comb begin
    probe_tile = '0;
    for (int k = 0; k < NUM_PROBES; k++)
      probe_tile[k*TILE_BITS +: TILE_BITS] = lookup(probe_x[k*10 +: 10], probe_y[k*10 +: 10],
                                                    BORDER_TILE);
  end

endmodule

// File: tb/tb_tile_map_scroller.sv
// Bench for tile_map_scroller: directed scenarios plus randomized writes, scrolls and
// lookups checked against a pixel-level reference grid held in the bench.
`timescale 1ns/1ps
module tb_tile_map_scroller;
  localparam int NC = 10, NR = 10, TB = 3, NP = 6, TPX = 40, OX = 120, OY = 40;
`ifdef SOLID_BORDER_EN
  localparam int BORDER = 7;
`else
  localparam int BORDER = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              shift_req;
  logic              busy, ready;
  logic              wr_en;
  logic [9:0]        wr_x, wr_y;
  logic [TB-1:0]     wr_tile;
  logic [9:0]        drawX, drawY;
  logic [TB-1:0]     tile_out;
  logic [NP*10-1:0]  probe_x, probe_y;
  logic [NP*TB-1:0]  probe_tile;
  logic [7:0]        current_col;

  tile_map_scroller_if #(.COL_ADDR_W(8), .NUM_ROWS(NR), .TILE_BITS(TB)) col_bus ();

  tile_map_scroller dut (
    .Clk(Clk), .Reset_n(Reset_n), .shift_req(shift_req), .busy(busy), .ready(ready),
    .col(col_bus), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_tile(wr_tile),
    .drawX(drawX), .drawY(drawY), .tile_out(tile_out), .probe_x(probe_x),
    .probe_y(probe_y), .probe_tile(probe_tile), .current_col(current_col)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int model [NC][NR];
  int model_cur;
  int px [NP];
  int py [NP];

  // Reference lookup straight from the pixel rules.
  function automatic int ref_tile(int x, int y, int oor);
    if (x < OX || x >= OX + NC*TPX || y < OY || y >= OY + NR*TPX) return oor;
    return model[(x - OX) / TPX][(y - OY) / TPX];
  endfunction

  function automatic void model_shift(logic [NR*TB-1:0] d);
    for (int c = 0; c < NC - 1; c++)
      for (int r = 0; r < NR; r++) model[c][r] = model[c+1][r];
    for (int r = 0; r < NR; r++) model[NC-1][r] = int'(d[r*TB +: TB]);
  endfunction

  function automatic void model_write(int x, int y, int t, bit on_shift);
    int tx, ty;
    if (x < OX || x >= OX + NC*TPX || y < OY || y >= OY + NR*TPX) return;
    tx = (x - OX) / TPX;
    ty = (y - OY) / TPX;
    if (!on_shift) model[tx][ty] = t;
    else if (tx > 0) model[tx-1][ty] = t;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) model[c][r] = 0;
    model_cur = 0;
  endfunction

  task automatic apply_probes();
    for (int k = 0; k < NP; k++) begin
      probe_x[k*10 +: 10] = 10'(px[k]);
      probe_y[k*10 +: 10] = 10'(py[k]);
    end
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (col_bus.col_req !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    ok = (col_bus.col_req === 1'b1);
  endtask

  // One scroll: pulse shift_req, answer the request after lat idle cycles.
  task automatic do_shift(input logic [NR*TB-1:0] d, input int lat, input bit wr,
                          input int wx, input int wy, input int wt, output bit ok);
    shift_req = 1'b1;
    @(negedge Clk);
    shift_req = 1'b0;
    wait_req(ok);
    if (!ok) return;
    repeat (lat) @(negedge Clk);
    col_bus.col_valid = 1'b1;
    col_bus.col_data  = d;
    if (wr) begin
      wr_en = 1'b1; wr_x = 10'(wx); wr_y = 10'(wy); wr_tile = TB'(wt);
    end
    @(negedge Clk);
    col_bus.col_valid = 1'b0;
    wr_en = 1'b0;
    model_shift(d);
    if (wr) model_write(wx, wy, wt, 1'b1);
    model_cur = (model_cur + 1) % 256;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; shift_req = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0;
    drawX = 10'd125; drawY = 10'd45; probe_x = '0; probe_y = '0;
    col_bus.col_valid = 1'b0; col_bus.col_data = '0;
    model_clear();
    repeat (2) @(negedge Clk);
    checks++; if (col_bus.col_req !== 1'b0) begin errors++; $display("FAIL reset_col_req: got %b required 0", col_bus.col_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ready); end
    checks++; if (current_col !== 8'd0) begin errors++; $display("FAIL reset_current_col: got %0d required 0", current_col); end
    checks++; if (tile_out !== 3'd0) begin errors++; $display("FAIL reset_tile_out: got %0d required 0", tile_out); end
    Reset_n = 1'b1;
  endtask

  task automatic test_fill();
    bit ok;
    logic [NR*TB-1:0] d;
    for (int c = 0; c < NC; c++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_req%0d: got %b required 1", c, col_bus.col_req); return; end
      checks++; if (col_bus.col_addr !== 8'(c)) begin errors++; $display("FAIL fill_addr%0d: got %0d required %0d", c, col_bus.col_addr, c); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fill_ready%0d: got %b required 0", c, ready); end
      @(negedge Clk);
      for (int r = 0; r < NR; r++) d[r*TB +: TB] = TB'(c);
      col_bus.col_valid = 1'b1;
      col_bus.col_data  = d;
      if (c == 3) begin
        wr_en = 1'b1; wr_x = 10'd245; wr_y = 10'd45; wr_tile = 3'd5; shift_req = 1'b1;
      end
      @(negedge Clk);
      col_bus.col_valid = 1'b0; wr_en = 1'b0; shift_req = 1'b0;
      for (int r = 0; r < NR; r++) model[c][r] = c % 8;
      model_cur++;
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill_done_ready: got %b required 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_done_busy: got %b required 0", busy); end
    checks++; if (col_bus.col_req !== 1'b0) begin errors++; $display("FAIL fill_done_req: got %b required 0", col_bus.col_req); end
    checks++; if (current_col !== 8'(model_cur)) begin errors++; $display("FAIL fill_current_col: got %0d required %0d", current_col, model_cur); end
    drawX = 10'd125; drawY = 10'd45;
    px[0] = 245; py[0] = 45;
    apply_probes();
    @(negedge Clk);
    checks++; if (tile_out !== TB'(ref_tile(125, 45, 0))) begin errors++; $display("FAIL fill_tile_out: got %0d required %0d", tile_out, ref_tile(125, 45, 0)); end
    checks++; if (probe_tile[0 +: TB] !== TB'(ref_tile(245, 45, BORDER))) begin errors++; $display("FAIL fill_write_dropped: got %0d required %0d", probe_tile[0 +: TB], ref_tile(245, 45, BORDER)); end
  endtask

  task automatic test_write();
    int old_v;
    old_v = ref_tile(285, 85, 0);
    wr_en = 1'b1; wr_x = 10'd285; wr_y = 10'd85; wr_tile = 3'd3;
    drawX = 10'd285; drawY = 10'd85;
    px[0] = 285; py[0] = 85;
    apply_probes();
    @(negedge Clk);
    wr_en = 1'b0;
    model_write(285, 85, 3, 1'b0);
    checks++; if (probe_tile[0 +: TB] !== 3'd3) begin errors++; $display("FAIL write_probe: got %0d required 3", probe_tile[0 +: TB]); end
    checks++; if (tile_out !== TB'(old_v)) begin errors++; $display("FAIL write_tile_out_early: got %0d required %0d", tile_out, old_v); end
    @(negedge Clk);
    checks++; if (tile_out !== 3'd3) begin errors++; $display("FAIL write_tile_out: got %0d required 3", tile_out); end
  endtask

  task automatic test_shift();
    logic [NR*TB-1:0] d;
    int e;
    shift_req = 1'b1;
    @(negedge Clk);
    shift_req = 1'b0;
    checks++; if (col_bus.col_req !== 1'b1) begin errors++; $display("FAIL shift_req_start: got %b required 1", col_bus.col_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shift_busy: got %b required 1", busy); end
    checks++; if (col_bus.col_addr !== 8'(model_cur)) begin errors++; $display("FAIL shift_addr: got %0d required %0d", col_bus.col_addr, model_cur); end
    for (int i = 0; i < 5; i++) begin
      shift_req = (i == 2);
      @(negedge Clk);
      checks++; if (col_bus.col_req !== 1'b1) begin errors++; $display("FAIL shift_req_hold%0d: got %b required 1", i, col_bus.col_req); end
    end
    shift_req = 1'b0;
    d = '1;
    col_bus.col_valid = 1'b1; col_bus.col_data = d;
    wr_en = 1'b1; wr_x = 10'd125; wr_y = 10'd45; wr_tile = 3'd5;
    @(negedge Clk);
    col_bus.col_valid = 1'b0; wr_en = 1'b0;
    model_shift(d);
    model_write(125, 45, 5, 1'b1);
    model_cur++;
    checks++; if (current_col !== 8'(model_cur)) begin errors++; $display("FAIL shift_current_col: got %0d required %0d", current_col, model_cur); end
    checks++; if (col_bus.col_req !== 1'b0) begin errors++; $display("FAIL shift_req_end: got %b required 0", col_bus.col_req); end
    px[0] = 485; py[0] = 45;  px[1] = 125; py[1] = 45;  px[2] = 125; py[2] = 85;
    px[3] = 245; py[3] = 85;  px[4] = 445; py[4] = 45;  px[5] = 165; py[5] = 45;
    apply_probes();
    #1;
    for (int k = 0; k < NP; k++) begin
      e = ref_tile(px[k], py[k], BORDER);
      checks++; if (probe_tile[k*TB +: TB] !== TB'(e)) begin errors++; $display("FAIL shift_probe%0d (%0d,%0d): got %0d required %0d", k, px[k], py[k], probe_tile[k*TB +: TB], e); end
    end
    @(negedge Clk);
    checks++; if (col_bus.col_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL shift_not_queued: got req=%b busy=%b required 0 0", col_bus.col_req, busy); end
  endtask

  task automatic test_shift_write();
    bit ok;
    int ty, wy, wt, e;
    for (int pass = 0; pass < 2; pass++) begin
      ty = $urandom_range(0, NR - 1);
      wy = OY + ty*TPX + $urandom_range(0, TPX - 1);
      wt = $urandom_range(1, 7);
      do_shift(30'($urandom), pass, 1'b1, OX + (pass == 0 ? 5 : 9)*TPX + $urandom_range(0, TPX - 1),
               wy, wt, ok);
      checks++; if (!ok) begin errors++; $display("FAIL shift_write_req%0d: got 0 required 1", pass); end
      for (int k = 0; k < NP; k++) begin
        px[k] = OX + (pass == 0 ? 3 + k : 4 + k)*TPX - ((pass != 0 && k == 5) ? NC*TPX : 0) + 20;
        py[k] = (k < 3) ? wy : OY + $urandom_range(0, NR*TPX - 1);
      end
      apply_probes();
      #1;
      for (int k = 0; k < NP; k++) begin
        e = ref_tile(px[k], py[k], BORDER);
        checks++; if (probe_tile[k*TB +: TB] !== TB'(e)) begin errors++; $display("FAIL shift_write%0d_probe%0d (%0d,%0d): got %0d required %0d", pass, k, px[k], py[k], probe_tile[k*TB +: TB], e); end
      end
    end
  endtask

  task automatic test_border();
    int e;
    px[0] = 119; py[0] = 50;  px[1] = 520; py[1] = 50;  px[2] = 120; py[2] = 50;
    px[3] = 519; py[3] = 50;  px[4] = 300; py[4] = 39;  px[5] = 300; py[5] = 439;
    apply_probes();
    drawX = 10'd119; drawY = 10'd50;
    wr_en = 1'b1; wr_x = 10'd1023; wr_y = 10'd50; wr_tile = 3'd6;
    @(negedge Clk);
    wr_en = 1'b0;
    for (int k = 0; k < NP; k++) begin
      e = ref_tile(px[k], py[k], BORDER);
      checks++; if (probe_tile[k*TB +: TB] !== TB'(e)) begin errors++; $display("FAIL border_probe%0d (%0d,%0d): got %0d required %0d", k, px[k], py[k], probe_tile[k*TB +: TB], e); end
    end
    @(negedge Clk);
    checks++; if (tile_out !== 3'd0) begin errors++; $display("FAIL border_tile_out: got %0d required 0", tile_out); end
  endtask

  task automatic test_random();
    bit ok;
    int op, e, wx, wy, wt, dx, dy;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      wx = $urandom_range(80, 560); wy = $urandom_range(0, 480); wt = $urandom_range(0, 7);
      if (op == 0) begin
        wr_en = 1'b1; wr_x = 10'(wx); wr_y = 10'(wy); wr_tile = TB'(wt);
        @(negedge Clk);
        wr_en = 1'b0;
        model_write(wx, wy, wt, 1'b0);
      end else if (op == 1) begin
        do_shift(30'($urandom), $urandom_range(0, 3), 1'($urandom), wx, wy, wt, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_req%0d: got 0 required 1", it); end
        checks++; if (current_col !== 8'(model_cur)) begin errors++; $display("FAIL rand_current_col%0d: got %0d required %0d", it, current_col, model_cur); end
      end
      for (int k = 0; k < NP; k++) begin
        px[k] = $urandom_range(80, 560); py[k] = $urandom_range(0, 480);
      end
      px[0] = wx; py[0] = wy;
      apply_probes();
      dx = $urandom_range(80, 560); dy = $urandom_range(0, 480);
      drawX = 10'(dx); drawY = 10'(dy);
      #1;
      for (int k = 0; k < NP; k++) begin
        e = ref_tile(px[k], py[k], BORDER);
        checks++; if (probe_tile[k*TB +: TB] !== TB'(e)) begin errors++; $display("FAIL rand%0d_probe%0d (%0d,%0d): got %0d required %0d", it, k, px[k], py[k], probe_tile[k*TB +: TB], e); end
      end
      @(negedge Clk);
      e = ref_tile(dx, dy, 0);
      checks++; if (tile_out !== TB'(e)) begin errors++; $display("FAIL rand%0d_tile_out (%0d,%0d): got %0d required %0d", it, dx, dy, tile_out, e); end
    end
  endtask

  task automatic test_reset_midfetch();
    shift_req = 1'b1;
    @(negedge Clk);
    shift_req = 1'b0;
    checks++; if (col_bus.col_req !== 1'b1) begin errors++; $display("FAIL midfetch_req: got %b required 1", col_bus.col_req); end
    px[0] = 125; py[0] = 45;  px[1] = 485; py[1] = 45;
    apply_probes();
    Reset_n = 1'b0;
    #1;
    checks++; if (col_bus.col_req !== 1'b0) begin errors++; $display("FAIL midfetch_reset_req: got %b required 0", col_bus.col_req); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midfetch_reset_ready: got %b required 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midfetch_reset_busy: got %b required 1", busy); end
    checks++; if (current_col !== 8'd0) begin errors++; $display("FAIL midfetch_reset_col: got %0d required 0", current_col); end
    checks++; if (probe_tile[0 +: TB] !== 3'd0 || probe_tile[TB +: TB] !== 3'd0) begin errors++; $display("FAIL midfetch_reset_tiles: got %0d,%0d required 0,0", probe_tile[0 +: TB], probe_tile[TB +: TB]); end
    @(negedge Clk);
    model_clear();
    Reset_n = 1'b1;
    col_bus.col_valid = 1'b1; col_bus.col_data = '1;
    @(negedge Clk);
    col_bus.col_valid = 1'b0;
    test_fill();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write();
    test_shift();
    test_shift_write();
    test_border();
    test_random();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end
endmodule
